// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// Stage side is master; the controller is the slave.
interface pipe_ctrl_if #(
   parameter int PERF_W = 32,
   parameter int EXC_W  = 16
);
   logic              stallreq_if;
   logic              stallreq_id;
   logic              stallreq_ex;
   logic              stallreq_mem;
   logic              exc_req;
   logic [31:0]       exc_target;
   logic [4:0]        stall;
   logic [4:0]        flush;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              exc_pending;
   logic [PERF_W-1:0] stall_cnt;
   logic [EXC_W-1:0]  exc_cnt;

   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output exc_req, exc_target,
      input  stall, flush, redirect, redirect_pc,
      input  exc_pending, stall_cnt, exc_cnt
   );

   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  exc_req, exc_target,
      output stall, flush, redirect, redirect_pc,
      output exc_pending, stall_cnt, exc_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Merges stage stall requests, sequences exception redirects, counts events.
module pipe_ctrl #(
   parameter int PERF_W = 32,
   parameter int EXC_W  = 16
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic {RUN, PEND} state_t;

   state_t            state;
   logic [31:0]       pend_pc;
   logic [PERF_W-1:0] stall_cnt;
   logic [EXC_W-1:0]  exc_cnt;

   logic [4:0]  stall;
   logic [4:0]  flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [4:1]  win;

   // one-hot winner: highest requesting stage takes priority
   assign win[4] = bus.stallreq_mem;
   assign win[3] = bus.stallreq_ex & ~bus.stallreq_mem;
   assign win[2] = bus.stallreq_id & ~bus.stallreq_ex
                 & ~bus.stallreq_mem;
   assign win[1] = bus.stallreq_if & ~bus.stallreq_id
                 & ~bus.stallreq_ex & ~bus.stallreq_mem;

   always_comb begin
      stall       = 5'b00000;
      flush       = 5'b00000;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      if (rst) begin
         if (state == PEND) begin
            stall    = 5'b00001;
            flush    = bus.exc_req ? 5'b11110 : 5'b00010;
            redirect = ~bus.stallreq_if;
            if (!bus.stallreq_if)
               redirect_pc = bus.exc_req ? bus.exc_target : pend_pc;
         end else if (bus.exc_req) begin
            flush    = 5'b11110;
            redirect = ~bus.stallreq_if;
            if (!bus.stallreq_if)
               redirect_pc = bus.exc_target;
         end else begin
            unique case (1'b1)
               win[4]: begin
                  stall = 5'b01111;
                  flush = 5'b10000;
               end
               win[3]: begin
                  stall = 5'b00111;
                  flush = 5'b01000;
               end
               win[2]: begin
                  stall = 5'b00011;
                  flush = 5'b00100;
               end
               win[1]: begin
                  stall = 5'b00001;
                  flush = 5'b00010;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         pend_pc   <= 32'h0;
         stall_cnt <= '0;
         exc_cnt   <= '0;
      end else begin
         if (|stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (bus.exc_req)
            exc_cnt <= exc_cnt + 1'b1;
         if (bus.exc_req && bus.stallreq_if)
            pend_pc <= bus.exc_target;
         // stay/enter PEND only while the fetch is still outstanding
         if (bus.stallreq_if && (bus.exc_req || state == PEND))
            state <= PEND;
         else
            state <= RUN;
      end
   end

   assign bus.stall       = stall;
   assign bus.flush       = flush;
   assign bus.redirect    = redirect;
   assign bus.redirect_pc = redirect_pc;
   assign bus.exc_pending = rst && (state == PEND);
   assign bus.stall_cnt   = stall_cnt;
   assign bus.exc_cnt     = exc_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Merges per-stage stall requests and the MEM-stage exception request.
- Produces per-register stall and flush vectors that drive the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences the PC redirect to the exception vector: it defers the redirect while an instruction fetch is outstanding, and counts stall and exception events.

Parameters:
- PERF_W, 32, width of the stall-cycle counter.
- EXC_W, 16, width of the exception counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising clk).
- stallreq_if  in  1  IF busy (icache miss / fetch outstanding).
- stallreq_id  in  1  ID load-use hazard.
- stallreq_ex  in  1  EX multi-cycle op busy (divide).
- stallreq_mem  in  1  MEM busy (dcache miss).
- exc_req  in  1  MEM-stage instruction raised an exception.
- exc_target  in  32  exception handler address, valid with exc_req.
- stall  out  5  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB: hold register.
- flush  out  5  same indexing: load bubble (register's own flush input).
- redirect  out  1  PC must load redirect_pc this cycle.
- redirect_pc  out  32  redirect address.
- exc_pending  out  1  high in PEND state.
- stall_cnt  out  PERF_W  cycles with any stall bit set, saturating.
- exc_cnt  out  EXC_W  exceptions accepted, wrapping.

Behaviour:
- State: RUN, PEND (2 states). Registers: state, pend_pc[31:0], stall_cnt, exc_cnt.
- Reset (rst=0 at posedge): state=RUN, pend_pc=0, stall_cnt=0, exc_cnt=0.
- While rst=0, the combinational outputs are forced as follows: stall=0, flush=0, redirect=0, redirect_pc=0, exc_pending=0.
- Reset asserted while in PEND drops the pending redirect.
- stall, flush, redirect and redirect_pc are combinational from inputs and state (zero latency).
- RUN, exc_req=0: the highest-index requesting stage k wins (MEM=4 > EX=3 > ID=2 > IF=1).
  - stall[k-1:0]=1, flush[k]=1, all other bits 0. Examples: IF gives stall=00001, flush=00010; MEM gives stall=01111, flush=10000.
  - No request: stall=0, flush=0.
- RUN, exc_req=1: exception has priority over all stall requests. flush=11110, stall=00000, exc_cnt increments at the clock edge.
  - stallreq_if=0: redirect=1, redirect_pc=exc_target, stay RUN.
  - stallreq_if=1: redirect=0, pend_pc<=exc_target, next state PEND.
- PEND: exc_pending=1, stall=00001, flush=00010. The fetch is discarded via the IF/ID bubble.
  - stallreq_if=1: remain PEND.
  - stallreq_if=0: redirect=1, redirect_pc=pend_pc, next state RUN.
  - stallreq_id/ex/mem are ignored in PEND.
  - exc_req=1 in PEND overwrites pend_pc, increments exc_cnt, and asserts flush=11110 for that cycle. If stallreq_if=0 in that same cycle, redirect uses the new exc_target.
- stall_cnt increments by 1 when |stall=1 and rst=1. It saturates at all-ones. A redirect cycle with stall=0 does not count.
- exc_cnt wraps modulo 2^EXC_W.
- flush and stall are never both 1 for the same bit index.

Test Plan:
- Reset: rst=0 for 2 cycles with all requests high -> stall=0, flush=0, redirect=0, counters 0; after rst=1 with idle inputs -> stall=0, flush=0.
- Priority: stallreq_id=1 and stallreq_mem=1 together -> stall=01111, flush=10000; drop mem -> stall=00011, flush=00100; stall_cnt=2 after both cycles.
- Immediate exception: exc_req=1, exc_target=0xBFC00380, stallreq_mem=1, stallreq_if=0 -> flush=11110, stall=0, redirect=1, redirect_pc=0xBFC00380, exc_cnt=1, state RUN.
- Deferred exception: exc_req=1 with stallreq_if=1 for 3 further cycles, exc_target=0x80000180 -> redirect=0 and exc_pending=1 for 3 cycles with stall=00001, flush=00010. The first cycle with stallreq_if=0 gives redirect=1, redirect_pc=0x80000180, then RUN.
- Overwrite in PEND: enter PEND with 0x80000180, then exc_req=1 with target 0x80000200 while stallreq_if=1 -> exc_cnt=2; on release redirect_pc=0x80000200.
- Saturation: preload stall_cnt near max (PERF_W=4 build), hold stallreq_ex=1 for 20 cycles -> stall_cnt=0xF and stays there. Reset mid-PEND -> next cycle state RUN, no redirect.
